lut_sweep_checker: RTL and testbench

LUT_SWEEP_CHECKER -- requirements
Module: lut_sweep_checker

---
 rtl/lut_sweep_checker.sv | 120 ++++++++++++
 tb/tb_lut_sweep_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_checker.sv
// Exhaustive 5-input LUT sweeper: drives vectors 0..31, samples the LUT after SETTLE
// wait cycles, and records mismatches. Optional first-error capture under LUT_SWEEP_FIRST_ERR_EN.
module lut_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] golden,
  input  logic        lut_o,
  output logic [4:0]  lut_i,
  output logic        busy,
  output logic        done,
  output logic [5:0]  err_cnt,
  output logic [31:0] err_mask
`ifdef LUT_SWEEP_FIRST_ERR_EN
  , output logic [4:0] first_err
  , output logic       first_err_vld
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] golden_q, golden_d;
  logic [5:0]  err_cnt_q, err_cnt_d;
  logic [31:0] err_mask_q, err_mask_d;
  logic [4:0]  first_q, first_d;
  logic        fvld_q, fvld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      golden_q   <= '0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
      first_q    <= '0;
      fvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      golden_q   <= golden_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
      first_q    <= first_d;
      fvld_q     <= fvld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    golden_d   = golden_q;
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
    first_d    = first_q;
    fvld_d     = fvld_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          idx_d      = '0;
          cnt_d      = SETTLE_C;
          golden_d   = golden;
          err_cnt_d  = '0;
          err_mask_d = '0;
          first_d    = '0;
          fvld_d     = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (lut_o != golden_q[idx_q]) begin
            err_mask_d[idx_q] = 1'b1;
            err_cnt_d         = err_cnt_q + 6'd1;
            if (!fvld_q) begin
              first_d = idx_q;
              fvld_d  = 1'b1;
            end
          end
          // Last vector: leave idx at 31 so lut_i stays put through DONE.
          if (idx_q != 5'd31) begin
            idx_d = idx_q + 5'd1;
            cnt_d = SETTLE_C;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The vector index register doubles as the registered LUT drive.
  assign lut_i    = idx_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign err_cnt  = err_cnt_q;
  assign err_mask = err_mask_q;

`ifdef LUT_SWEEP_FIRST_ERR_EN
  assign first_err     = first_q;
  assign first_err_vld = fvld_q;
`else
  logic unused_first;
  assign unused_first = ^{first_q, fvld_q};
`endif

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Directed bench: three checker instances (SETTLE 0/1/2) driven from a vector table
// plus hand sequences for start-while-busy, mid-sweep reset and reset/start collision.
module tb_lut_sweep_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [3];
  logic [31:0] gold  [3];
  int          mode  [3];
  logic [2:0]  lut_o;
  logic [4:0]  lut_i [3];
  logic [2:0]  busy, done;
  logic [5:0]  ecnt  [3];
  logic [31:0] emask [3];
`ifdef LUT_SWEEP_FIRST_ERR_EN
  logic [4:0]  fe    [3];
  logic [2:0]  fv;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    // LUT model: 0 = tied low, 1 = tied high, 2 = follows golden but vector 31 inverted.
    assign lut_o[g] = (mode[g] == 0) ? 1'b0 :
                      (mode[g] == 1) ? 1'b1 :
                      (gold[g][lut_i[g]] ^ (lut_i[g] == 5'd31));
    lut_sweep_checker #(.SETTLE(g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .golden   (gold[g]),
      .lut_o    (lut_o[g]),
      .lut_i    (lut_i[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .err_cnt  (ecnt[g]),
      .err_mask (emask[g])
`ifdef LUT_SWEEP_FIRST_ERR_EN
      , .first_err     (fe[g])
      , .first_err_vld (fv[g])
`endif
    );
  end

  typedef struct {
    int          g;
    logic [31:0] golden;
    int          mode;
    int          lat;
    logic [5:0]  cnt;
    logic [31:0] mask;
    logic [4:0]  fe;
    logic        fv;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic sweep(input vec_t v);
    int  n;
    bit  seen;
    @(negedge clk);
    gold[v.g]  = v.golden;
    mode[v.g]  = v.mode;
    start[v.g] = 1'b1;
    @(posedge clk); #1;
    start[v.g] = 1'b0;
    chk("busy_after_start", 32'(busy[v.g]), 32'd1);
    n = 1;
    seen = 0;
    while (!seen && n < 4000) begin
      if (done[v.g]) seen = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(v.lat));
    chk("busy_in_done", 32'(busy[v.g]), 32'd0);
    chk("err_cnt", 32'(ecnt[v.g]), 32'(v.cnt));
    chk("err_mask", emask[v.g], v.mask);
`ifdef LUT_SWEEP_FIRST_ERR_EN
    chk("first_err", 32'(fe[v.g]), 32'(v.fe));
    chk("first_err_vld", 32'(fv[v.g]), 32'(v.fv));
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done[v.g]), 32'd0);
    chk("err_cnt_hold", 32'(ecnt[v.g]), 32'(v.cnt));
    chk("err_mask_hold", emask[v.g], v.mask);
  endtask

  initial begin
    int k;
    int pulses;
    int nbusy;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      gold[i]  = '0;
      mode[i]  = 0;
    end
    tbl[0] = '{0, 32'h0000_0000, 0, 33, 6'd0,  32'h0000_0000, 5'd0,  1'b0};
    tbl[1] = '{0, 32'h0000_0000, 1, 33, 6'd32, 32'hFFFF_FFFF, 5'd0,  1'b1};
    tbl[2] = '{2, 32'h8000_0001, 2, 97, 6'd1,  32'h8000_0000, 5'd31, 1'b1};
    tbl[3] = '{1, 32'hA5A5_0F0F, 1, 65, 6'd16, 32'h5A5A_F0F0, 5'd4,  1'b1};
    tbl[4] = '{1, 32'hA5A5_0F0F, 0, 65, 6'd16, 32'hA5A5_0F0F, 5'd0,  1'b1};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
      chk("rst_lut_i", 32'(lut_i[i]), 32'd0);
      chk("rst_err_cnt", 32'(ecnt[i]), 32'd0);
      chk("rst_err_mask", emask[i], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) sweep(tbl[i]);

    // start held high throughout RUN on SETTLE=1: one sweep, each vector held 2 cycles
    @(negedge clk);
    gold[1]  = 32'h0;
    mode[1]  = 0;
    start[1] = 1'b1;
    @(posedge clk); #1;
    k = 1;
    while (k < 200 && !done[1]) begin
      chk("held_lut_i", 32'(lut_i[1]), 32'((k - 1) / 2));
      @(posedge clk); #1;
      k++;
    end
    start[1] = 1'b0;
    chk("held_latency", 32'(k), 32'd65);
    pulses = 0;
    nbusy  = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done[1]) pulses++;
      if (busy[1]) nbusy++;
    end
    chk("held_extra_done", 32'(pulses), 32'd0);
    chk("held_no_restart", 32'(nbusy), 32'd0);

    // reset while lut_i = 10 mid-sweep
    @(negedge clk);
    gold[1]  = 32'h0;
    mode[1]  = 1;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    k = 0;
    while (k < 200 && lut_i[1] != 5'd10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mid_reached_10", 32'(lut_i[1]), 32'd10);
    chk("mid_err_cnt_pre", 32'(ecnt[1]), 32'd10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy[1]), 32'd0);
    chk("mid_rst_lut_i", 32'(lut_i[1]), 32'd0);
    chk("mid_rst_err_cnt", 32'(ecnt[1]), 32'd0);
    chk("mid_rst_err_mask", emask[1], 32'd0);
    chk("mid_rst_done", 32'(done[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    nbusy  = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done[1]) pulses++;
      if (busy[1]) nbusy++;
    end
    chk("mid_no_done", 32'(pulses), 32'd0);
    chk("mid_no_busy", 32'(nbusy), 32'd0);

    // rst and start together in IDLE
    @(negedge clk);
    rst      = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    start[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_idle", 32'(busy[0]), 32'd0);
    chk("rst_start_lut_i", 32'(lut_i[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
